cpu_axi_burst_bridge: RTL and testbench
=======================================

CPU_AXI_BURST_BRIDGE -- requirements
Module: cpu_axi_burst_bridge

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the CPU and AXI data width (32 or 64).
REQ-002 Parameter ADDR_WIDTH, default 32, is the address width.
REQ-003 Parameter ID_WIDTH, default 4, is the AXI ID width; instruction ID = 0, data ID = 1.
REQ-004 Parameter LINE_BYTES, default 32, is the address granule for read-after-write hazard compare.
REQ-005 Port clock, input, 1: single clock; all flops sample on the rising edge.
REQ-006 Port reset_, input, 1: asynchronous, active-low reset.
REQ-007 Ports inst_req_valid/inst_req_ready, in/out, 1: instruction read request handshake.
REQ-008 Ports inst_req_addr/inst_req_len/inst_req_size, in, ADDR_WIDTH/8/3: address, AXI beats-1, AXI size.
REQ-009 Ports inst_rdata/inst_rlast/inst_rvalid/inst_rready, out/out/out/in, DATA_WIDTH/1/1/1: instruction read beats.
REQ-010 Ports data_req_valid/data_req_ready/data_req_write, in/out/in, 1: data request handshake and direction.
REQ-011 Ports data_req_addr/data_req_len/data_req_size, in, ADDR_WIDTH/8/3: as REQ-008.
REQ-012 Ports data_wdata/data_wstrb/data_wvalid/data_wready, in/in/in/out, DATA_WIDTH/DATA_WIDTH/8/1/1: write beats.
REQ-013 Ports data_rdata/data_rlast/data_rvalid/data_rready: as REQ-009 for data reads.
REQ-014 Port data_bvalid, out, 1: one-cycle pulse on write completion; data_bresp, out, 2: copied BRESP.
REQ-015 Ports axi_ar*, axi_r*, axi_aw*, axi_w*, axi_b*: full AXI4 master channels, widths from parameters.

Function
REQ-016 Each read client SHALL run an FSM RD_IDLE -> RD_ADDR -> RD_DATA -> RD_IDLE; req_ready = (state == RD_IDLE) and no hazard.
REQ-017 A request SHALL be registered on the valid&ready cycle T; axi_arvalid SHALL assert no earlier than T+1.
REQ-018 The AR channel SHALL be shared by a round-robin arbiter; on simultaneous RD_ADDR, the client not granted last SHALL win; the pointer after reset SHALL favour instruction.
REQ-019 AR fields SHALL be held stable while axi_arvalid is high and unaccepted; burst = INCR, lock/cache/prot = 0.
REQ-020 Both clients MAY have one read outstanding concurrently; R beats SHALL be routed by axi_rid, combinationally, with axi_rready = routed client rready.
REQ-021 A client SHALL return to RD_IDLE on the cycle after a routed beat with axi_rlast, valid and ready.
REQ-022 The write FSM SHALL be WR_IDLE -> WR_XFER -> WR_RESP -> WR_IDLE; in WR_XFER, AW and W proceed independently; flag aw_done records AW acceptance.
REQ-023 data_wready = axi_wready in WR_XFER; axi_wlast SHALL assert on beat (len) counted by an 8-bit beat counter; leave WR_XFER when aw_done and last beat accepted.
REQ-024 axi_bready SHALL be 1 in WR_RESP; on axi_bvalid, data_bvalid pulses for one cycle with data_bresp.
REQ-025 data_req_ready SHALL be 0 while either the data read FSM or the write FSM is not idle.
REQ-026 Hazard: a read request whose address matches the outstanding write address at LINE_BYTES granularity SHALL be stalled (req_ready = 0) until the write response is received.
REQ-027 A write response or R beat with an unexpected ID SHALL be accepted and ignored.

Reset
REQ-028 Reset assertion SHALL immediately force all FSMs idle and all AXI valid/ready outputs, client rvalid/data_bvalid and counters to 0; req_ready outputs SHALL be 0 while reset_ is low.
REQ-029 Reset mid-burst SHALL abandon the transfer without emitting further beats; datapath registers are not reset.

Structure
REQ-030 State enums, ID constants and AXI burst/response encodings SHALL live in package axi_bridge_pkg.
REQ-031 The read-client FSM SHALL be one sub-module, axi_read_client, instantiated twice.

Verification
REQ-032 Instruction read addr 0x1FC0_0000, len 7, RDATA 0..7 -> one AR (len 7, id 0); eight inst beats, rlast on 8th.
REQ-033 Instruction and data read requested in the same cycle -> AR order: instruction then data; next tie -> data first.
REQ-034 Interleaved R beats id 1,0,1 -> each beat routed only to matching client.
REQ-035 Write 0x8000_0040 len 1, AWREADY delayed 3 cycles, WREADY immediate -> two W beats, wlast on 2nd, one data_bvalid pulse.
REQ-036 Read 0x8000_0050 during outstanding write to 0x8000_0040 -> req_ready low until B accepted, AR issued afterwards.
REQ-037 reset_ low during a 4-beat read after beat 2 -> all valids 0 in the same cycle; FSMs idle after release.

Source files
------------

// File: rtl/axi_bridge_pkg.sv
// Shared types and encodings for the CPU-to-AXI4 burst bridge.
package axi_bridge_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_XFER = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;

  localparam int unsigned ID_INST = 0;
  localparam int unsigned ID_DATA = 1;

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_read_client.sv
// One read client: captures a request, waits for its AR grant, then
// tracks R beats until the last one is taken.
module axi_read_client
  import axi_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_W-1:0]      req_len,
  input  logic [SIZE_W-1:0]     req_size,
  input  logic                  hazard,
  output logic                  ar_pending,
  input  logic                  ar_accept,
  input  logic                  beat_valid,
  input  logic                  beat_ready,
  input  logic                  beat_last,
  output logic                  in_data,
  output logic                  idle,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [LEN_W-1:0]      len,
  output logic [SIZE_W-1:0]     size
);

  rd_state_e state_q, state_d;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) state_q <= RD_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE: if (req_valid && req_ready)                 state_d = RD_ADDR;
      RD_ADDR: if (ar_accept)                              state_d = RD_DATA;
      RD_DATA: if (beat_valid && beat_ready && beat_last)  state_d = RD_IDLE;
      default:                                             state_d = RD_IDLE;
    endcase
  end

  assign idle       = (state_q == RD_IDLE);
  assign ar_pending = (state_q == RD_ADDR);
  assign in_data    = (state_q == RD_DATA);
  assign req_ready  = reset_ && idle && !hazard;

  // Request payload is datapath only; it is meaningless until the FSM leaves idle.
  always_ff @(posedge clock) begin
    if (req_valid && req_ready) begin
      addr <= req_addr;
      len  <= req_len;
      size <= req_size;
    end
  end

endmodule

// File: rtl/cpu_axi_burst_bridge.sv
// Bridges an instruction read port and a data read/write port onto one
// AXI4 master, with a shared AR arbiter and a read-after-write line hazard.
module cpu_axi_burst_bridge
  import axi_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned LINE_BYTES = 32
) (
  input  logic                    clock,
  input  logic                    reset_,
  input  logic                    inst_req_valid,
  output logic                    inst_req_ready,
  input  logic [ADDR_WIDTH-1:0]   inst_req_addr,
  input  logic [7:0]              inst_req_len,
  input  logic [2:0]              inst_req_size,
  output logic [DATA_WIDTH-1:0]   inst_rdata,
  output logic                    inst_rlast,
  output logic                    inst_rvalid,
  input  logic                    inst_rready,
  input  logic                    data_req_valid,
  output logic                    data_req_ready,
  input  logic                    data_req_write,
  input  logic [ADDR_WIDTH-1:0]   data_req_addr,
  input  logic [7:0]              data_req_len,
  input  logic [2:0]              data_req_size,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_wstrb,
  input  logic                    data_wvalid,
  output logic                    data_wready,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    data_rlast,
  output logic                    data_rvalid,
  input  logic                    data_rready,
  output logic                    data_bvalid,
  output logic [1:0]              data_bresp,
  output logic [ID_WIDTH-1:0]     axi_arid,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [7:0]              axi_arlen,
  output logic [2:0]              axi_arsize,
  output logic [1:0]              axi_arburst,
  output logic                    axi_arlock,
  output logic [3:0]              axi_arcache,
  output logic [2:0]              axi_arprot,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [ID_WIDTH-1:0]     axi_rid,
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]              axi_rresp,
  input  logic                    axi_rlast,
  input  logic                    axi_rvalid,
  output logic                    axi_rready,
  output logic [ID_WIDTH-1:0]     axi_awid,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]              axi_awlen,
  output logic [2:0]              axi_awsize,
  output logic [1:0]              axi_awburst,
  output logic                    axi_awlock,
  output logic [3:0]              axi_awcache,
  output logic [2:0]              axi_awprot,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wlast,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  input  logic [ID_WIDTH-1:0]     axi_bid,
  input  logic [1:0]              axi_bresp,
  input  logic                    axi_bvalid,
  output logic                    axi_bready
);

  localparam int unsigned LINE_SHIFT = $clog2(LINE_BYTES);

  logic                  inst_pending, inst_in_data, inst_idle, inst_accept, inst_hit, inst_hazard;
  logic                  data_pending, data_in_data, data_idle, data_accept, data_hit;
  logic [ADDR_WIDTH-1:0] inst_addr, data_addr;
  logic [LEN_W-1:0]      inst_len, data_len;
  logic [SIZE_W-1:0]     inst_size, data_size;

  wr_state_e             wr_state_q, wr_state_d;
  logic                  wr_busy, wr_start;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [LEN_W-1:0]      wr_len_q;
  logic [SIZE_W-1:0]     wr_size_q;

  logic unused_rresp;
  assign unused_rresp = ^axi_rresp;

  assign wr_busy     = (wr_state_q != WR_IDLE);
  assign inst_hazard = wr_busy &&
                       (inst_req_addr[ADDR_WIDTH-1:LINE_SHIFT] == wr_addr_q[ADDR_WIDTH-1:LINE_SHIFT]);

  // Data port is single-issue: any busy write blocks data reads and writes alike.
  assign wr_start = data_req_valid && data_req_write && data_req_ready;

  axi_read_client #(.ADDR_WIDTH(ADDR_WIDTH)) u_inst_client (
    .clock      (clock),
    .reset_     (reset_),
    .req_valid  (inst_req_valid),
    .req_ready  (inst_req_ready),
    .req_addr   (inst_req_addr),
    .req_len    (inst_req_len),
    .req_size   (inst_req_size),
    .hazard     (inst_hazard),
    .ar_pending (inst_pending),
    .ar_accept  (inst_accept),
    .beat_valid (inst_hit),
    .beat_ready (inst_rready),
    .beat_last  (axi_rlast),
    .in_data    (inst_in_data),
    .idle       (inst_idle),
    .addr       (inst_addr),
    .len        (inst_len),
    .size       (inst_size)
  );

  axi_read_client #(.ADDR_WIDTH(ADDR_WIDTH)) u_data_client (
    .clock      (clock),
    .reset_     (reset_),
    .req_valid  (data_req_valid && !data_req_write),
    .req_ready  (data_req_ready),
    .req_addr   (data_req_addr),
    .req_len    (data_req_len),
    .req_size   (data_req_size),
    .hazard     (wr_busy),
    .ar_pending (data_pending),
    .ar_accept  (data_accept),
    .beat_valid (data_hit),
    .beat_ready (data_rready),
    .beat_last  (axi_rlast),
    .in_data    (data_in_data),
    .idle       (data_idle),
    .addr       (data_addr),
    .len        (data_len),
    .size       (data_size)
  );

  // AR arbiter: the favour pointer moves only on contested grants.
  logic ar_valid_q, ar_owner_q, last_data_q, grant_inst, grant_data;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [LEN_W-1:0]      ar_len_q;
  logic [SIZE_W-1:0]     ar_size_q;

  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (!ar_valid_q) begin
      if (inst_pending && data_pending) begin
        grant_inst = last_data_q;
        grant_data = !last_data_q;
      end else begin
        grant_inst = inst_pending;
        grant_data = data_pending;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      ar_valid_q  <= 1'b0;
      ar_owner_q  <= 1'b0;
      last_data_q <= 1'b1;
    end else if (grant_inst || grant_data) begin
      ar_valid_q <= 1'b1;
      ar_owner_q <= grant_data;
      if (inst_pending && data_pending) last_data_q <= grant_data;
    end else if (ar_valid_q && axi_arready) begin
      ar_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (grant_inst || grant_data) begin
      ar_addr_q <= grant_data ? data_addr : inst_addr;
      ar_len_q  <= grant_data ? data_len  : inst_len;
      ar_size_q <= grant_data ? data_size : inst_size;
    end
  end

  assign inst_accept = ar_valid_q && axi_arready && !ar_owner_q;
  assign data_accept = ar_valid_q && axi_arready &&  ar_owner_q;

  assign axi_arvalid = ar_valid_q;
  assign axi_arid    = ar_owner_q ? ID_WIDTH'(ID_DATA) : ID_WIDTH'(ID_INST);
  assign axi_araddr  = ar_addr_q;
  assign axi_arlen   = ar_len_q;
  assign axi_arsize  = ar_size_q;
  assign axi_arburst = BURST_INCR;
  assign axi_arlock  = 1'b0;
  assign axi_arcache = 4'b0000;
  assign axi_arprot  = 3'b000;

  // R routing by ID; beats nobody is waiting for are drained and dropped.
  assign inst_hit    = axi_rvalid && (axi_rid == ID_WIDTH'(ID_INST)) && inst_in_data;
  assign data_hit    = axi_rvalid && (axi_rid == ID_WIDTH'(ID_DATA)) && data_in_data;
  assign inst_rvalid = inst_hit;
  assign data_rvalid = data_hit;
  assign inst_rdata  = axi_rdata;
  assign data_rdata  = axi_rdata;
  assign inst_rlast  = axi_rlast;
  assign data_rlast  = axi_rlast;
  assign axi_rready  = reset_ && (inst_hit ? inst_rready : (data_hit ? data_rready : 1'b1));

  // Write path.
  logic                aw_done_q, w_done_q, aw_fire, w_fire, b_hit;
  logic [LEN_W-1:0]    beat_cnt_q;

  assign aw_fire = axi_awvalid && axi_awready;
  assign w_fire  = axi_wvalid && axi_wready;
  assign b_hit   = axi_bvalid && axi_bready && (axi_bid == ID_WIDTH'(ID_DATA));

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) wr_state_q <= WR_IDLE;
    else         wr_state_q <= wr_state_d;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_IDLE: if (wr_start) wr_state_d = WR_XFER;
      WR_XFER: if ((aw_done_q || aw_fire) && (w_done_q || (w_fire && axi_wlast)))
                 wr_state_d = WR_RESP;
      WR_RESP: if (b_hit) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      beat_cnt_q  <= '0;
      data_bvalid <= 1'b0;
      data_bresp  <= RESP_OKAY;
    end else begin
      data_bvalid <= b_hit;
      if (b_hit) data_bresp <= axi_bresp;
      if (wr_state_q == WR_IDLE) begin
        aw_done_q  <= 1'b0;
        w_done_q   <= 1'b0;
        beat_cnt_q <= '0;
      end else begin
        if (aw_fire) aw_done_q <= 1'b1;
        if (w_fire) begin
          if (axi_wlast) w_done_q   <= 1'b1;
          else           beat_cnt_q <= beat_cnt_q + LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_start) begin
      wr_addr_q <= data_req_addr;
      wr_len_q  <= data_req_len;
      wr_size_q <= data_req_size;
    end
  end

  assign axi_awvalid = (wr_state_q == WR_XFER) && !aw_done_q;
  assign axi_awid    = ID_WIDTH'(ID_DATA);
  assign axi_awaddr  = wr_addr_q;
  assign axi_awlen   = wr_len_q;
  assign axi_awsize  = wr_size_q;
  assign axi_awburst = BURST_INCR;
  assign axi_awlock  = 1'b0;
  assign axi_awcache = 4'b0000;
  assign axi_awprot  = 3'b000;

  assign axi_wvalid  = (wr_state_q == WR_XFER) && !w_done_q && data_wvalid;
  assign data_wready = (wr_state_q == WR_XFER) && !w_done_q && axi_wready;
  assign axi_wdata   = data_wdata;
  assign axi_wstrb   = data_wstrb;
  assign axi_wlast   = (beat_cnt_q == wr_len_q);
  assign axi_bready  = (wr_state_q == WR_RESP);

endmodule

// File: tb/tb_cpu_axi_burst_bridge.sv
// Directed bench for cpu_axi_burst_bridge acting as a hand-driven AXI slave.
module tb_cpu_axi_burst_bridge;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = 4;

  logic          clock, reset_;
  logic          inst_req_valid, inst_req_ready;
  logic [AW-1:0] inst_req_addr;
  logic [7:0]    inst_req_len;
  logic [2:0]    inst_req_size;
  logic [DW-1:0] inst_rdata;
  logic          inst_rlast, inst_rvalid, inst_rready;
  logic          data_req_valid, data_req_ready, data_req_write;
  logic [AW-1:0] data_req_addr;
  logic [7:0]    data_req_len;
  logic [2:0]    data_req_size;
  logic [DW-1:0] data_wdata;
  logic [DW/8-1:0] data_wstrb;
  logic          data_wvalid, data_wready;
  logic [DW-1:0] data_rdata;
  logic          data_rlast, data_rvalid, data_rready, data_bvalid;
  logic [1:0]    data_bresp;
  logic [IW-1:0] axi_arid, axi_awid, axi_rid, axi_bid;
  logic [AW-1:0] axi_araddr, axi_awaddr;
  logic [7:0]    axi_arlen, axi_awlen;
  logic [2:0]    axi_arsize, axi_awsize, axi_arprot, axi_awprot;
  logic [1:0]    axi_arburst, axi_awburst, axi_rresp, axi_bresp;
  logic          axi_arlock, axi_awlock;
  logic [3:0]    axi_arcache, axi_awcache;
  logic          axi_arvalid, axi_arready, axi_awvalid, axi_awready;
  logic [DW-1:0] axi_rdata, axi_wdata;
  logic [DW/8-1:0] axi_wstrb;
  logic          axi_rlast, axi_rvalid, axi_rready, axi_wlast, axi_wvalid, axi_wready;
  logic          axi_bvalid, axi_bready;

  int vectors = 0;
  int miscompares = 0;

  cpu_axi_burst_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .LINE_BYTES(32)) dut (
    .clock(clock), .reset_(reset_),
    .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready), .inst_req_addr(inst_req_addr),
    .inst_req_len(inst_req_len), .inst_req_size(inst_req_size),
    .inst_rdata(inst_rdata), .inst_rlast(inst_rlast), .inst_rvalid(inst_rvalid), .inst_rready(inst_rready),
    .data_req_valid(data_req_valid), .data_req_ready(data_req_ready), .data_req_write(data_req_write),
    .data_req_addr(data_req_addr), .data_req_len(data_req_len), .data_req_size(data_req_size),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_wvalid(data_wvalid), .data_wready(data_wready),
    .data_rdata(data_rdata), .data_rlast(data_rlast), .data_rvalid(data_rvalid), .data_rready(data_rready),
    .data_bvalid(data_bvalid), .data_bresp(data_bresp),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awlock(axi_awlock), .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_arvalid();
    for (int n = 0; n < 20 && axi_arvalid !== 1'b1; n++) step();
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    inst_req_valid = 0; inst_req_addr = '0; inst_req_len = '0; inst_req_size = 3'd2; inst_rready = 1;
    data_req_valid = 0; data_req_write = 0; data_req_addr = '0; data_req_len = '0; data_req_size = 3'd2;
    data_wdata = '0; data_wstrb = '1; data_wvalid = 0; data_rready = 1;
    axi_arready = 0; axi_rid = '0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 0; axi_rvalid = 0;
    axi_awready = 0; axi_wready = 0; axi_bid = '0; axi_bresp = '0; axi_bvalid = 0;
    #2; step();
    vectors++;
    if ({axi_arvalid, axi_awvalid, axi_wvalid, axi_rready, axi_bready} !== 5'b0) begin
      miscompares++; $display("FAIL reset_axi got %b want 00000", {axi_arvalid, axi_awvalid, axi_wvalid, axi_rready, axi_bready});
    end
    vectors++;
    if ({inst_req_ready, data_req_ready, inst_rvalid, data_rvalid, data_bvalid} !== 5'b0) begin
      miscompares++; $display("FAIL reset_client got %b want 00000", {inst_req_ready, data_req_ready, inst_rvalid, data_rvalid, data_bvalid});
    end
    step();
    reset_ = 1'b1; #1;
    vectors++;
    if ({inst_req_ready, data_req_ready} !== 2'b11) begin
      miscompares++; $display("FAIL reset_release_ready got %b want 11", {inst_req_ready, data_req_ready});
    end
  endtask

  task automatic test_inst_burst();
    inst_req_addr = 32'h1FC0_0000; inst_req_len = 8'd7; inst_req_valid = 1; #1;
    vectors++;
    if (inst_req_ready !== 1'b1) begin miscompares++; $display("FAIL burst_req_ready got %b want 1", inst_req_ready); end
    step(); inst_req_valid = 0; #1;
    vectors++;
    if (axi_arvalid !== 1'b0) begin miscompares++; $display("FAIL burst_ar_early got %b want 0", axi_arvalid); end
    wait_arvalid();
    vectors++;
    if ({axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst} !== {1'b1, 4'd0, 32'h1FC0_0000, 8'd7, 3'd2, 2'b01}) begin
      miscompares++; $display("FAIL burst_ar got v=%b id=%0d a=%h len=%0d sz=%0d b=%b want v=1 id=0 a=1fc00000 len=7 sz=2 b=01",
        axi_arvalid, axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst);
    end
    axi_arready = 1; step(); axi_arready = 0; #1;
    vectors++;
    if (axi_arvalid !== 1'b0) begin miscompares++; $display("FAIL burst_ar_drop got %b want 0", axi_arvalid); end
    for (int i = 0; i < 8; i++) begin
      axi_rvalid = 1; axi_rid = 4'd0; axi_rdata = 32'(i); axi_rlast = (i == 7); #1;
      vectors++;
      if ({inst_rvalid, data_rvalid, inst_rlast, axi_rready, inst_rdata} !== {1'b1, 1'b0, (i == 7), 1'b1, 32'(i)}) begin
        miscompares++; $display("FAIL burst_beat%0d got v=%b dv=%b l=%b rr=%b d=%h want v=1 dv=0 l=%b rr=1 d=%h",
          i, inst_rvalid, data_rvalid, inst_rlast, axi_rready, inst_rdata, (i == 7), 32'(i));
      end
      step();
    end
    axi_rvalid = 0; axi_rlast = 0; #1;
    vectors++;
    if ({inst_req_ready, axi_arvalid} !== 2'b10) begin
      miscompares++; $display("FAIL burst_done got rdy/arv=%b want 10", {inst_req_ready, axi_arvalid});
    end
  endtask

  task automatic test_tie_order();
    inst_req_addr = 32'h0000_1000; inst_req_len = 0; data_req_addr = 32'h0000_2000; data_req_len = 0;
    inst_req_valid = 1; data_req_valid = 1; data_req_write = 0; #1;
    vectors++;
    if ({inst_req_ready, data_req_ready} !== 2'b11) begin
      miscompares++; $display("FAIL tie1_ready got %b want 11", {inst_req_ready, data_req_ready});
    end
    step(); inst_req_valid = 0; data_req_valid = 0;
    wait_arvalid();
    vectors++;
    if ({axi_arvalid, axi_arid, axi_araddr} !== {1'b1, 4'd0, 32'h0000_1000}) begin
      miscompares++; $display("FAIL tie1_first got v=%b id=%0d a=%h want v=1 id=0 a=00001000", axi_arvalid, axi_arid, axi_araddr);
    end
    axi_arready = 1; step(); axi_arready = 0;
    wait_arvalid();
    vectors++;
    if ({axi_arvalid, axi_arid, axi_araddr} !== {1'b1, 4'd1, 32'h0000_2000}) begin
      miscompares++; $display("FAIL tie1_second got v=%b id=%0d a=%h want v=1 id=1 a=00002000", axi_arvalid, axi_arid, axi_araddr);
    end
    axi_arready = 1; step(); axi_arready = 0;
    axi_rvalid = 1; axi_rid = 4'd0; axi_rlast = 1; axi_rdata = 32'hAAAA; step();
    axi_rid = 4'd1; axi_rdata = 32'hBBBB; step();
    axi_rvalid = 0; axi_rlast = 0; #1;
    vectors++;
    if ({inst_req_ready, data_req_ready} !== 2'b11) begin
      miscompares++; $display("FAIL tie1_idle got %b want 11", {inst_req_ready, data_req_ready});
    end
  endtask

  task automatic test_interleave();
    int ids [3] = '{1, 0, 1};
    logic lasts [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0] exp_v;
    inst_req_addr = 32'h0000_3000; inst_req_len = 0; data_req_addr = 32'h0000_4000; data_req_len = 1;
    inst_req_valid = 1; data_req_valid = 1; data_req_write = 0;
    step(); inst_req_valid = 0; data_req_valid = 0;
    wait_arvalid();
    vectors++;
    if ({axi_arvalid, axi_arid, axi_araddr, axi_arlen} !== {1'b1, 4'd1, 32'h0000_4000, 8'd1}) begin
      miscompares++; $display("FAIL tie2_first got v=%b id=%0d a=%h len=%0d want v=1 id=1 a=00004000 len=1", axi_arvalid, axi_arid, axi_araddr, axi_arlen);
    end
    axi_arready = 1; step(); axi_arready = 0;
    wait_arvalid();
    vectors++;
    if ({axi_arvalid, axi_arid, axi_araddr} !== {1'b1, 4'd0, 32'h0000_3000}) begin
      miscompares++; $display("FAIL tie2_second got v=%b id=%0d a=%h want v=1 id=0 a=00003000", axi_arvalid, axi_arid, axi_araddr);
    end
    axi_arready = 1; step(); axi_arready = 0;
    for (int k = 0; k < 3; k++) begin
      axi_rvalid = 1; axi_rid = IW'(ids[k]); axi_rlast = lasts[k]; axi_rdata = 32'h1100 + 32'(k); #1;
      exp_v = (ids[k] == 0) ? 2'b10 : 2'b01;
      vectors++;
      if ({inst_rvalid, data_rvalid} !== exp_v ||
          ((ids[k] == 0) ? inst_rdata : data_rdata) !== 32'h1100 + 32'(k)) begin
        miscompares++; $display("FAIL interleave_beat%0d got iv/dv=%b id=%h dd=%h want iv/dv=%b data=%h",
          k, {inst_rvalid, data_rvalid}, inst_rdata, data_rdata, exp_v, 32'h1100 + 32'(k));
      end
      step();
    end
    axi_rvalid = 0; axi_rlast = 0; #1;
    vectors++;
    if ({inst_req_ready, data_req_ready} !== 2'b11) begin
      miscompares++; $display("FAIL interleave_idle got %b want 11", {inst_req_ready, data_req_ready});
    end
  endtask

  task automatic test_write();
    data_req_addr = 32'h8000_0040; data_req_len = 8'd1; data_req_write = 1; data_req_valid = 1;
    axi_wready = 1; #1;
    vectors++;
    if (data_req_ready !== 1'b1) begin miscompares++; $display("FAIL wr_req_ready got %b want 1", data_req_ready); end
    step(); data_req_valid = 0; data_req_write = 0;
    data_wvalid = 1; data_wdata = 32'hA0; #1;
    vectors++;
    if ({axi_awvalid, axi_awid, axi_awaddr, axi_awlen, axi_awburst} !== {1'b1, 4'd1, 32'h8000_0040, 8'd1, 2'b01}) begin
      miscompares++; $display("FAIL wr_aw got v=%b id=%0d a=%h len=%0d b=%b want v=1 id=1 a=80000040 len=1 b=01",
        axi_awvalid, axi_awid, axi_awaddr, axi_awlen, axi_awburst);
    end
    vectors++;
    if ({axi_wvalid, axi_wlast, data_wready, axi_wdata} !== {3'b101, 32'hA0}) begin
      miscompares++; $display("FAIL wr_beat0 got v/l/r=%b d=%h want 101 d=a0", {axi_wvalid, axi_wlast, data_wready}, axi_wdata);
    end
    step(); data_wdata = 32'hA1; #1;
    vectors++;
    if ({axi_wvalid, axi_wlast, data_wready, axi_wdata, axi_awvalid} !== {3'b111, 32'hA1, 1'b1}) begin
      miscompares++; $display("FAIL wr_beat1 got v/l/r=%b d=%h awv=%b want 111 d=a1 awv=1", {axi_wvalid, axi_wlast, data_wready}, axi_wdata, axi_awvalid);
    end
    step(); #1;
    vectors++;
    if ({axi_wvalid, data_wready, axi_awvalid} !== 3'b001) begin
      miscompares++; $display("FAIL wr_no_extra_beat got wv/wr/awv=%b want 001", {axi_wvalid, data_wready, axi_awvalid});
    end
    step(); data_wvalid = 0; axi_awready = 1; #1;
    step(); axi_awready = 0; #1;
    vectors++;
    if ({axi_awvalid, axi_bready, data_bvalid} !== 3'b010) begin
      miscompares++; $display("FAIL wr_resp_state got awv/br/bv=%b want 010", {axi_awvalid, axi_bready, data_bvalid});
    end
    axi_bvalid = 1; axi_bid = 4'd1; axi_bresp = 2'b10; step(); axi_bvalid = 0; #1;
    vectors++;
    if ({data_bvalid, data_bresp, axi_bready} !== 4'b1100) begin
      miscompares++; $display("FAIL wr_bvalid got bv/resp/br=%b want 1100", {data_bvalid, data_bresp, axi_bready});
    end
    step();
    vectors++;
    if ({data_bvalid, data_req_ready} !== 2'b01) begin
      miscompares++; $display("FAIL wr_bvalid_pulse got bv/rdy=%b want 01", {data_bvalid, data_req_ready});
    end
  endtask

  task automatic test_hazard();
    data_req_addr = 32'h8000_0040; data_req_len = 0; data_req_write = 1; data_req_valid = 1;
    step(); data_req_valid = 0; data_req_write = 0;
    axi_awready = 1; axi_wready = 1; data_wvalid = 1; data_wdata = 32'h55;
    step(); axi_awready = 0; data_wvalid = 0;
    inst_req_len = 0; inst_req_addr = 32'h8000_0060; #1;
    vectors++;
    if (inst_req_ready !== 1'b1) begin miscompares++; $display("FAIL haz_other_line got %b want 1", inst_req_ready); end
    inst_req_addr = 32'h8000_005C; #1;
    vectors++;
    if ({inst_req_ready, data_req_ready} !== 2'b00) begin
      miscompares++; $display("FAIL haz_line_end got %b want 00", {inst_req_ready, data_req_ready});
    end
    inst_req_addr = 32'h8000_0050; inst_req_valid = 1;
    axi_bvalid = 1; axi_bid = 4'd3; axi_bresp = 2'b00; step(); axi_bvalid = 0; #1;
    vectors++;
    if ({inst_req_ready, data_bvalid, axi_bready, axi_arvalid} !== 4'b0010) begin
      miscompares++; $display("FAIL haz_stray_b got rdy/bv/br/arv=%b want 0010", {inst_req_ready, data_bvalid, axi_bready, axi_arvalid});
    end
    axi_bvalid = 1; axi_bid = 4'd1; step(); axi_bvalid = 0; #1;
    vectors++;
    if ({inst_req_ready, data_bvalid, axi_arvalid} !== 3'b110) begin
      miscompares++; $display("FAIL haz_release got rdy/bv/arv=%b want 110", {inst_req_ready, data_bvalid, axi_arvalid});
    end
    step(); inst_req_valid = 0;
    wait_arvalid();
    vectors++;
    if ({axi_arvalid, axi_arid, axi_araddr} !== {1'b1, 4'd0, 32'h8000_0050}) begin
      miscompares++; $display("FAIL haz_ar got v=%b id=%0d a=%h want v=1 id=0 a=80000050", axi_arvalid, axi_arid, axi_araddr);
    end
    axi_arready = 1; step(); axi_arready = 0;
    axi_rvalid = 1; axi_rid = 4'd0; axi_rlast = 1; step(); axi_rvalid = 0; axi_rlast = 0;
  endtask

  task automatic test_reset_mid();
    inst_req_addr = 32'h0000_0100; inst_req_len = 8'd3; inst_req_valid = 1;
    step(); inst_req_valid = 0;
    wait_arvalid();
    axi_arready = 1; step(); axi_arready = 0;
    for (int i = 0; i < 2; i++) begin
      axi_rvalid = 1; axi_rid = 4'd0; axi_rdata = 32'(i); axi_rlast = 0; step();
    end
    axi_rdata = 32'd2; reset_ = 1'b0; #1;
    vectors++;
    if ({inst_rvalid, axi_rready, axi_arvalid, inst_req_ready, data_req_ready, axi_awvalid, axi_wvalid, axi_bready, data_bvalid} !== 9'b0) begin
      miscompares++; $display("FAIL midreset_outputs got %b want 000000000",
        {inst_rvalid, axi_rready, axi_arvalid, inst_req_ready, data_req_ready, axi_awvalid, axi_wvalid, axi_bready, data_bvalid});
    end
    step(); step(); reset_ = 1'b1; axi_rvalid = 0; #1;
    vectors++;
    if ({inst_req_ready, data_req_ready} !== 2'b11) begin
      miscompares++; $display("FAIL midreset_idle got %b want 11", {inst_req_ready, data_req_ready});
    end
    axi_rvalid = 1; axi_rid = 4'd0; axi_rlast = 1; #1;
    vectors++;
    if ({inst_rvalid, axi_rready} !== 2'b01) begin
      miscompares++; $display("FAIL midreset_stray_r got iv/rr=%b want 01", {inst_rvalid, axi_rready});
    end
    step(); axi_rvalid = 0; axi_rlast = 0;
  endtask

  initial begin
    test_reset();
    test_inst_burst();
    test_tie_order();
    test_interleave();
    test_write();
    test_hazard();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
